truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper_pkg.sv | 21 ++
 rtl/truth_table_sweeper_sync_2ff.sv | 21 ++
 rtl/truth_table_sweeper.sv | 117 +++++++++++
 tb/tb_truth_table_sweeper.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper family (row indexing, FSM states).
// Kept width-generic so 2- and 4-input sweepers can reuse the same row/bit mapping.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int ROW_W  = 3;
  localparam int N_ROWS = 1 << ROW_W;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

  // Row 0 lands in the table MSB, matching the hex convention for gate codes.
  function automatic logic [ROW_W-1:0] row_to_bit(input logic [ROW_W-1:0] row);
    return ROW_LAST - row;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 3-input block through all rows, samples its output after a settle window
// and reports the measured truth table against an expected code.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int               SETTLE_CYCLES = 16,
  parameter logic [N_ROWS-1:0] EXPECTED     = 8'hD6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              in1,
  output logic              in2,
  output logic              in3,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic [N_ROWS-1:0] table_out,
  output logic [N_ROWS-1:0] mismatch,
  output logic              pass
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // The synchroniser eats two cycles of the settle window, so anything shorter
  // would sample the previous row.
  if (SETTLE_CYCLES < 3) begin : g_settle_too_short
    $error("truth_table_sweeper: SETTLE_CYCLES must be at least 3");
  end

  state_t            state;
  logic [ROW_W-1:0]  row;
  logic [CNT_W-1:0]  cnt;
  logic [N_ROWS-1:0] work;
  logic [N_ROWS-1:0] table_next;
  logic              dut_sync;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (dut_sync)
  );

  always_comb begin
    table_next = work;
    table_next[row_to_bit(row)] = dut_sync;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      row             <= '0;
      cnt             <= '0;
      work            <= '0;
      {in1, in2, in3} <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      table_out       <= '0;
      mismatch        <= '0;
      pass            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          {in1, in2, in3} <= '0;
          if (start) begin
            state <= SETTLE;
            row   <= '0;
            cnt   <= '0;
            work  <= '0;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state           <= IDLE;
            {in1, in2, in3} <= '0;
            busy            <= 1'b0;
          end else begin
            {in1, in2, in3} <= row;
            cnt             <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state           <= IDLE;
            {in1, in2, in3} <= '0;
            busy            <= 1'b0;
          end else begin
            work <= table_next;
            if (row == ROW_LAST) begin
              state           <= DONE;
              done            <= 1'b1;
              busy            <= 1'b0;
              {in1, in2, in3} <= '0;
              table_out       <= table_next;
              mismatch        <= table_next ^ EXPECTED;
              pass            <= (table_next == EXPECTED);
            end else begin
              state           <= SETTLE;
              row             <= row + 1'b1;
              cnt             <= '0;
              {in1, in2, in3} <= row + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a gate model driven by the sweeper's stimulus,
// table-driven and random sweeps, plus restart/abort/reset sequences.
module tb_truth_table_sweeper;

  localparam int SC  = 16;
  localparam int PER = SC + 1;
  localparam int LAT = 8 * PER + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dut_out;
  logic       in1, in2, in3, busy, done, pass;
  logic [7:0] table_out, mismatch;
  logic [7:0] model_tt = 8'hD6;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Gate model: output at row r is truth-table bit 7-r.
  assign dut_out = model_tt[3'd7 - {in1, in2, in3}];

  truth_table_sweeper #(.SETTLE_CYCLES(SC), .EXPECTED(8'hD6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .table_out (table_out),
    .mismatch  (mismatch),
    .pass      (pass)
  );

  typedef struct {
    logic [7:0] model;
    logic [7:0] exp_table;
    logic [7:0] exp_mis;
    logic       exp_pass;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " inputs"}, {29'd0, in1, in2, in3}, 32'd0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " table_out"}, table_out, 0);
    chk({tag, " mismatch"}, mismatch, 0);
    chk({tag, " pass"}, pass, 0);
  endtask

  // One full sweep; schedule of stimulus/busy/done is checked every cycle.
  task automatic do_sweep(input string tag, input logic [7:0] m, input bit repulse,
                          input bit with_abort);
    int bad, first_bad, extra, exp_row;
    logic [7:0] et, em;
    logic ep;
    et = m;
    em = m ^ 8'hD6;
    ep = (m == 8'hD6);
    model_tt = m;
    bad = 0;
    first_bad = -1;
    extra = 0;
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    for (int n = 1; n <= LAT; n++) begin
      @(negedge clk);
      abort = 1'b0;
      start = repulse && (n == 5 || n == 60 || n == LAT);
      exp_row = (n < LAT) ? (n - 1) / PER : 0;
      if ({in1, in2, in3} !== 3'(exp_row) || busy !== (n < LAT) || done !== (n == LAT)) begin
        bad++;
        if (first_bad < 0) first_bad = n;
      end
      if (n == LAT) begin
        chk({tag, " table_out"}, table_out, et);
        chk({tag, " mismatch"}, mismatch, em);
        chk({tag, " pass"}, pass, ep);
      end
    end
    chk($sformatf("%s schedule (first bad cycle %0d)", tag, first_bad), bad, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done || busy) extra++;
    end
    chk({tag, " idle after done"}, extra, 0);
  endtask

  initial begin
    vec_t vecs[4];
    int dones, stray;
    logic [7:0] r;

    vecs[0] = '{8'hD6, 8'hD6, 8'h00, 1'b1};
    vecs[1] = '{8'h00, 8'h00, 8'hD6, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'h29, 1'b0};
    vecs[3] = '{8'hF6, 8'hF6, 8'h20, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("reset");

    for (int i = 0; i < 4; i++)
      do_sweep($sformatf("vec%0d", i), vecs[i].model, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom);
      do_sweep($sformatf("rand%0d_%02h", i, r), r, 1'b0, 1'b0);
    end

    do_sweep("repulse", 8'hD6, 1'b1, 1'b0);
    do_sweep("start_abort_idle", 8'hD6, 1'b0, 1'b1);

    // Abort in row 4 settle after a passing sweep.
    model_tt = 8'h00;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort pre row", {29'd0, in1, in2, in3}, 32'd4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort inputs", {29'd0, in1, in2, in3}, 32'd0);
    chk("abort done", done, 0);
    chk("abort table_out kept", table_out, 8'hD6);
    chk("abort mismatch kept", mismatch, 8'h00);
    chk("abort pass kept", pass, 1);
    dones = 0;
    stray = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) stray++;
    end
    chk("abort no done", dones, 0);
    chk("abort stays idle", stray, 0);

    // Reset during row 5.
    model_tt = 8'hD6;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 90; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midreset pre row", {29'd0, in1, in2, in3}, 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("midreset");
    do_sweep("after_reset", 8'hD6, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
